// File: rtl/add_serial.sv
// Nibble-serial adder: s = a + b + ci, one 4-bit slice per clock, LSB nibble first.
// Optional signed-overflow output enabled by defining ADD_OVF_EN.
module add_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic [3:0]       nib_a, nib_b;
  logic [4:0]       slice_sum;
  logic             last_slice;
`ifdef ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
    slice_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    last_slice = (idx_q == IDX_W'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) begin
            psum_d[4*i +: 4] = slice_sum[3:0];
          end
        end
        carry_d = slice_sum[4];
        idx_d   = idx_q + IDX_W'(1);
        // The result only becomes visible once the top slice has been folded in.
        if (last_slice) begin
          s_d     = psum_d;
          co_d    = slice_sum[4];
          idx_d   = '0;
          state_d = ST_DONE;
`ifdef ADD_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (psum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign co   = co_q;
`ifdef ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
